// File: rtl/div_seq_8bit_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding, default operand width and the iteration-counter width helper.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Width of a counter that has to reach width-1; never narrower than 1 bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_seq_8bit_addsub.sv
// Combinational add/sub unit: sum = a + (sub ? ~b : b) + cin.
// With sub=1 and cin=1 this is a - b, and cout=1 means no borrow.
module addsub_unit #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] w_b_eff;

  // Conditionally invert b, then one wide add produces carry-out and sum.
  always_comb begin
    w_b_eff     = sub ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, cin};
  end

endmodule

// File: rtl/div_seq_8bit.sv
// Sequential restoring divider, one trial subtraction per clock.
// IDLE accepts start; CALC runs WIDTH iterations; DONE presents results
// for one cycle and may accept a back-to-back start.
// | state | meaning                                         |
// | IDLE  | waiting for start                               |
// | CALC  | shifting/subtracting, busy=1                    |
// | DONE  | one-cycle done pulse, start accepted here too   |
module div_seq_8bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_last;
  logic [WIDTH:0]   w_p_sh;
  logic [WIDTH:0]   w_t;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_p_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_unused_t_msb;

  assign w_div_zero = (divisor == '0);
  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last     = (r_cnt == CNT_LAST);

  // The partial remainder always stays below the divisor, so it is kept in
  // WIDTH bits; shifting in the next dividend bit gives the WIDTH+1 trial operand.
  assign w_p_sh = {r_p, r_q[WIDTH-1]};

  addsub_unit #(.WIDTH(WIDTH + 1)) u_addsub (
    .a   (w_p_sh),
    .b   ({1'b0, r_divisor}),
    .sub (1'b1),
    .cin (1'b1),
    .sum (w_t),
    .cout(w_no_borrow)
  );

  // A successful trial difference is below the divisor, so its MSB is always 0.
  assign w_unused_t_msb = w_t[WIDTH];

  // Restore step: keep the difference only when the subtraction did not borrow.
  always_comb begin
    w_p_nxt = w_no_borrow ? w_t[WIDTH-1:0] : w_p_sh[WIDTH-1:0];
    w_q_nxt = {r_q[WIDTH-2:0], w_no_borrow};
  end

  // Next-state and status outputs decoded from the current state.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = w_div_zero ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_state_nxt = w_div_zero ? DONE : CALC;
        else       w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture, shift/subtract iterations and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt       <= '0;
      r_p         <= '0;
      r_q         <= dividend;
      r_divisor   <= divisor;
      div_by_zero <= w_div_zero;
      if (w_div_zero) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (r_state == CALC) begin
      r_p <= w_p_nxt;
      r_q <= w_q_nxt;
      if (w_last) begin
        r_cnt     <= '0;
        quotient  <= w_q_nxt;
        remainder <= w_p_nxt;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_seq_8bit.sv
// Self-checking bench for div_seq_8bit: expected results are queued when a
// start is driven and compared when the done pulse appears.
module tb_div_seq_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  typedef struct {
    int q;
    int r;
    int dz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  div_seq_8bit #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive a start in the current cycle and queue the reference result.
  task automatic launch(input int a, input int b);
    exp_t e;
    start    = 1'b1;
    dividend = a[7:0];
    divisor  = b[7:0];
    if (b == 0) begin
      e.q = 255; e.r = a; e.dz = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 0;
    end
    sb.push_back(e);
  endtask

  // Wait (bounded) for done, measuring latency and busy cycles; optionally
  // pulse an extra start on busy cycle inj_cyc, which must be ignored.
  task automatic wait_done(input int exp_lat, input int inj_cyc);
    int   lat = 0;
    int   busy_cnt = 0;
    exp_t e;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) lat = n;
      else if (n == inj_cyc) begin
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
      end
    end
    chk("done_lat", lat, exp_lat);
    chk("busy_cycles", busy_cnt, (exp_lat > 1) ? exp_lat - 1 : 0);
    chk("sb_size", sb.size(), 1);
    if (lat != 0 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("quotient", quotient, e.q);
      chk("remainder", remainder, e.r);
      chk("div_by_zero", div_by_zero, e.dz);
    end
  endtask

  initial begin
    int cnt;
    int a;
    int b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dz", div_by_zero, 0);

    // Basic divide, then confirm done is a single-cycle pulse and results hold.
    launch(100, 7);
    wait_done(9, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("held_quot", quotient, 14);
    chk("held_rem", remainder, 2);

    @(negedge clk); launch(255, 1);   wait_done(9, 0);
    @(negedge clk); launch(5, 200);   wait_done(9, 0);
    @(negedge clk); launch(200, 200); wait_done(9, 0);
    @(negedge clk); launch(50, 0);    wait_done(1, 0);

    // Start pulsed during busy must not disturb the running operation.
    @(negedge clk); launch(60, 7);    wait_done(9, 3);

    // Reset on the 4th busy cycle discards the pending result.
    @(negedge clk);
    launch(100, 7);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_quot", quotient, 0);
    chk("midrst_rem", remainder, 0);
    chk("midrst_dz", div_by_zero, 0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("midrst_quiet", cnt, 0);
    @(negedge clk); launch(17, 5);    wait_done(9, 0);

    // Reset and start together: reset wins, nothing starts.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 8'd50; divisor = 8'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    cnt = 0;
    repeat (4) begin
      if (done || busy) cnt++;
      @(negedge clk);
    end
    chk("rst_start_quiet", cnt, 0);

    // Back-to-back: the next start is issued in the done cycle.
    @(negedge clk); launch(100, 7);   wait_done(9, 0);
    launch(81, 9);                    wait_done(9, 0);
    launch(40, 0);                    wait_done(1, 0);
    launch(13, 4);                    wait_done(9, 0);

    // Random operands, occasional zero divisor.
    for (int k = 0; k < 24; k++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      @(negedge clk);
      launch(a, b);
      wait_done((b == 0) ? 1 : 9, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
